// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants and FSM state encoding.
// Imported by the hazard detector and the pipeline control top.
package pipe_ctrl_pkg;

  localparam int ADDR_LEN = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'd0,
    PCTRL_LD_BUB   = 2'd1,
    PCTRL_MEM_WAIT = 2'd2,
    PCTRL_FLUSH    = 2'd3
  } pctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard compare between the load in EX
// and the source operands of the instruction in ID.
module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_ld,
  input  logic [4:0] ex_wb_addr,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_vld,
  input  logic       id_rs2_vld,
  output logic       ld_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_vld && (id_rs1 == ex_wb_addr);
  assign rs2_hit = id_rs2_vld && (id_rs2 == ex_wb_addr);

  // x0 is never written, so a load to x0 cannot create a hazard
  assign ld_use = ex_ld && (ex_wb_addr != 5'd0)
               && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use bubbles, jump squashes,
// LSU wait stalls and LSU timeout detection.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LD_BUB_CYC = 1,
  parameter int unsigned MEM_TMO    = 64
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                jmp_req_i,
  input  logic [ADDR_LEN-1:0] jmp_addr_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic                id_rs1_vld_i,
  input  logic                id_rs2_vld_i,
  input  logic                ex_ld_i,
  input  logic [4:0]          ex_wb_addr_i,
  input  logic                mem_req_i,
  input  logic                mem_ack_i,
  output logic                pc_stall_o,
  output logic                if_stall_o,
  output logic                id_stall_o,
  output logic                ex_stall_o,
  output logic                if_flush_o,
  output logic                id_flush_o,
  output logic                pc_set_o,
  output logic [ADDR_LEN-1:0] pc_set_addr_o,
  output logic                err_o
);

  localparam logic [2:0] BUB_INIT = 3'(LD_BUB_CYC - 1);
  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);
  localparam logic       MULTI_BUB = (LD_BUB_CYC > 1);

  pctrl_state_e state_q;
  pctrl_state_e state_d;
  logic [2:0]   bub_q;
  logic [2:0]   bub_d;
  logic [7:0]   tmo_q;
  logic [7:0]   tmo_d;

  logic ld_use;
  logic mem_wait;
  logic in_wait;
  logic in_bub;
  logic in_flush;
  logic do_tmo;
  logic do_wait;
  logic do_jmp;
  logic do_bub;
  logic do_fl;
  logic do_lu;

  hazard_det u_hazard_det (
    .ex_ld      (ex_ld_i),
    .ex_wb_addr (ex_wb_addr_i),
    .id_rs1     (id_rs1_i),
    .id_rs2     (id_rs2_i),
    .id_rs1_vld (id_rs1_vld_i),
    .id_rs2_vld (id_rs2_vld_i),
    .ld_use     (ld_use)
  );

  assign mem_wait = mem_req_i && !mem_ack_i;
  assign in_wait  = (state_q == PCTRL_MEM_WAIT);
  assign in_bub   = (state_q == PCTRL_LD_BUB);
  assign in_flush = (state_q == PCTRL_FLUSH);

  // tmo_q counts wait cycles already spent, so the
  // current cycle is the MEM_TMO-th one at MEM_TMO-1
  assign do_tmo  = in_wait && mem_wait
                && (tmo_q == TMO_LAST);
  assign do_wait = mem_wait && !do_tmo;
  assign do_jmp  = !mem_wait && jmp_req_i;
  assign do_bub  = !mem_wait && !jmp_req_i && in_bub;
  assign do_fl   = !mem_wait && !jmp_req_i && in_flush;
  assign do_lu   = !mem_wait && !jmp_req_i
                && !in_bub && !in_flush && ld_use;

  always_comb begin
    state_d       = PCTRL_RUN;
    bub_d         = 3'd0;
    tmo_d         = 8'd0;
    pc_stall_o    = DISABLE;
    if_stall_o    = DISABLE;
    id_stall_o    = DISABLE;
    ex_stall_o    = DISABLE;
    if_flush_o    = DISABLE;
    id_flush_o    = DISABLE;
    pc_set_o      = DISABLE;
    pc_set_addr_o = '0;
    err_o         = DISABLE;
    if (!rst_) begin
      if_flush_o = ENABLE;
      id_flush_o = ENABLE;
    end else begin
      unique case (1'b1)
        do_tmo: begin
          err_o      = ENABLE;
          if_flush_o = ENABLE;
          id_flush_o = ENABLE;
        end
        do_wait: begin
          pc_stall_o = ENABLE;
          if_stall_o = ENABLE;
          id_stall_o = ENABLE;
          ex_stall_o = ENABLE;
          state_d    = PCTRL_MEM_WAIT;
          tmo_d      = in_wait ? tmo_q + 8'd1 : 8'd1;
        end
        do_jmp: begin
          pc_set_o      = ENABLE;
          pc_set_addr_o = jmp_addr_i;
          if_flush_o    = ENABLE;
          id_flush_o    = ENABLE;
          state_d       = PCTRL_FLUSH;
        end
        do_bub: begin
          pc_stall_o = ENABLE;
          if_stall_o = ENABLE;
          id_flush_o = ENABLE;
          bub_d      = bub_q - 3'd1;
          state_d    = (bub_q == 3'd1) ? PCTRL_RUN
                                       : PCTRL_LD_BUB;
        end
        do_fl: begin
          if_flush_o = ENABLE;
        end
        do_lu: begin
          pc_stall_o = ENABLE;
          if_stall_o = ENABLE;
          id_flush_o = ENABLE;
          if (MULTI_BUB) begin
            bub_d   = BUB_INIT;
            state_d = PCTRL_LD_BUB;
          end
        end
        default: begin
          state_d = PCTRL_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= PCTRL_RUN;
      bub_q   <= 3'd0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage RV32I core. It takes hazard and event inputs from IDU, EXU and LSU and drives the `flush`/`stall` pairs that every stage register (IF/ID, ID/EX, EX/MEM) and the PC consume. It also drives the PC redirect. It resolves load-use bubbles, taken-jump squashes and multi-cycle LSU waits with a small FSM and two counters, and flags LSU bus timeouts.

## Interface
- `LD_BUB_CYC`, default 1: bubble cycles inserted on a load-use hazard (1..7).
- `MEM_TMO`, default 64: maximum LSU wait cycles before abort (2..255).
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_`  in  1  reset, synchronous, active-low.
- `jmp_req_i`  in  1  EXU: taken branch/jump resolved this cycle.
- `jmp_addr_i`  in  `ADDR_LEN`  EXU: redirect target.
- `id_rs1_i`, `id_rs2_i`  in  5 each  IDU: source register indices.
- `id_rs1_vld_i`, `id_rs2_vld_i`  in  1 each  IDU: the instruction reads that source.
- `ex_ld_i`  in  1  EXU: instruction in EX is a load.
- `ex_wb_addr_i`  in  5  EXU: destination register of the instruction in EX.
- `mem_req_i`  in  1  LSU: access in MEM is outstanding.
- `mem_ack_i`  in  1  LSU: access completes this cycle.
- `pc_stall_o`, `if_stall_o`, `id_stall_o`, `ex_stall_o`  out  1 each  hold PC / IF/ID / ID/EX / EX/MEM.
- `if_flush_o`, `id_flush_o`  out  1 each  load NOP into IF/ID / ID/EX.
- `pc_set_o`  out  1  load `pc_set_addr_o` into PC.
- `pc_set_addr_o`  out  `ADDR_LEN`  redirect address.
- `err_o`  out  1  one-cycle pulse on LSU timeout.

## Operation
- States: RUN, LD_BUB, MEM_WAIT, FLUSH. Counters: `bub_cnt` (3 b) and `tmo_cnt` (8 b).
- All outputs are Mealy, combinational from state and inputs. All use `ENABLE`/`DISABLE`.
- **Load-use hazard:** `ex_ld_i && ex_wb_addr_i!=0 && ((id_rs1_vld_i && id_rs1_i==ex_wb_addr_i) || (id_rs2_vld_i && id_rs2_i==ex_wb_addr_i))`.
- **Priority in every state:** mem-wait > jump > load-use.
- **Mem-wait:** condition is `mem_req_i && !mem_ack_i`.
  - Assert all four stalls; no flush; `pc_set_o=0`.
  - EXU holds `jmp_req_i` because EX is frozen, so the jump is taken after the wait.
  - RUN/LD_BUB/FLUSH → MEM_WAIT, `tmo_cnt<=1`. The interrupted LD_BUB or FLUSH work is dropped.
- **Jump:** `pc_set_o=1`, `pc_set_addr_o=jmp_addr_i`, `if_flush_o=1`, `id_flush_o=1`, no stalls. Next state is FLUSH.
- **FLUSH (one cycle):**
  - `if_flush_o=1` squashes the in-flight fetch. Hazard detection is ignored because ID holds a NOP.
  - Returns to RUN unless a new jump arrives, which restarts FLUSH.
- **Load-use in RUN:**
  - `pc_stall_o=if_stall_o=1`, `id_flush_o=1`.
  - If `LD_BUB_CYC>1`: go to LD_BUB with `bub_cnt<=LD_BUB_CYC-1`.
- **LD_BUB:**
  - Same stall/flush outputs as load-use in RUN; `bub_cnt` decrements each cycle.
  - Go to RUN in the cycle `bub_cnt==1`.
- **MEM_WAIT:**
  - `mem_ack_i` → RUN. Stalls drop the same cycle.
  - Otherwise `tmo_cnt` increments. At `tmo_cnt==MEM_TMO` without ack: `err_o=1`, stalls released, `ex_stall_o=0` and `if_flush_o=id_flush_o=1`, → RUN.
- `mem_req_i && mem_ack_i` in the same cycle is not a wait: no stall.
- **Reset:** while `rst_==0`, both flushes are `ENABLE`, all stalls, `pc_set_o` and `err_o` are 0, and `pc_set_addr_o=0`. On the clock edge with `rst_==0`: state RUN, both counters 0. This holds from any state, including mid-wait.

## Timing
- Load-use: the stall is visible in the detect cycle. Total bubble is exactly `LD_BUB_CYC` cycles.
- Jump: redirect and flush in cycle N; FLUSH in N+1; first fetch from the target is valid in IF/ID at N+2.
- Mem-wait: stalls follow `mem_ack_i` combinationally, with zero added latency after ack.
- Timeout: fires in the `MEM_TMO`-th consecutive waiting cycle.

## Structure
- FSM state encodings go in shared `core.h` as `PCTRL_RUN`, `PCTRL_LD_BUB`, `PCTRL_MEM_WAIT` and `PCTRL_FLUSH`, beside `ENABLE`/`DISABLE`/`ADDR_LEN`.
- One sub-module, `hazard_det`, is natural: the purely combinational load-use compare.

## Test plan
- EX `lw x5`, ID `add x6,x5,x7` → `pc_stall_o/if_stall_o/id_flush_o`=1 for exactly 1 cycle. Repeat with `LD_BUB_CYC=3` → 3 cycles. With `ex_wb_addr_i=0` → no stall.
- `jmp_req_i=1`, `jmp_addr_i=0x80` → same cycle `pc_set_o=1`, addr 0x80, both flushes. Next cycle only `if_flush_o=1`. Then idle.
- `mem_req_i=1` for 5 cycles, ack in cycle 5 → all stalls high cycles 1–4, low in cycle 5, `err_o=0`.
- `mem_req_i` held with no ack, `MEM_TMO=64` → `err_o` pulses in cycle 64, flushes asserted, state RUN.
- Simultaneous cases:
  - Jump + load-use → jump behaviour only.
  - Jump + mem wait → stall; jump taken in the ack cycle.
- `rst_=0` in cycle 3 of MEM_WAIT → flushes high and stalls low during reset. After release, RUN with `tmo_cnt=0`.
